addsub_axil_regs: RTL and testbench
===================================

ADDSUB_AXIL_REGS -- requirements
Module: addsub_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI4-Lite address width; decode uses addr[15:2] only.
REQ-002 SHALL have parameter CTRL_RST, default 32'h0, meaning CTRL reset value.
REQ-003 SHALL have port axil_aclk, input, 1, meaning the single clock.
REQ-004 SHALL have port axil_arst, input, 1, meaning reset; synchronous and active-high (already decided).
REQ-005 SHALL have ports s_axil_awvalid/awready (in/out, 1) and s_axil_awaddr (in, ADDR_W), meaning the write-address channel.
REQ-006 SHALL have ports s_axil_wvalid/wready (in/out, 1) and s_axil_wdata (in, 32), meaning the write-data channel; there is no strobe and every write is full-word.
REQ-007 SHALL have ports s_axil_bvalid (out, 1), s_axil_bresp (out, 2) and s_axil_bready (in, 1), meaning the write-response channel.
REQ-008 SHALL have ports s_axil_arvalid/arready (in/out, 1) and s_axil_araddr (in, ADDR_W), meaning the read-address channel.
REQ-009 SHALL have ports s_axil_rvalid (out, 1), s_axil_rdata (out, 32), s_axil_rresp (out, 2) and s_axil_rready (in, 1), meaning the read-data channel.
REQ-010 SHALL have ports ctrl_enable (out, 1), ctrl_force_sub (out, 1) and operand (out, 32), meaning the calculator controls.
REQ-011 SHALL have ports status (in, 32), add_evt (in, 1) and sub_evt (in, 1), meaning the datapath status word and one-cycle operation pulses.

Function
REQ-012 SHALL implement this register map:
- 0x0000 ID: RO, 32'h41445342.
- 0x1000 CTRL: RW; bit0 drives ctrl_enable, bit1 drives ctrl_force_sub, bits[31:2] read 0.
- 0x1004 OPERAND: RW, drives operand.
- 0x1008 STATUS: RO, sampled status.
- 0x100C SCRATCH: RW.
REQ-013 SHALL run a write FSM with states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
- awready SHALL be high in W_IDLE and W_HAVE_DATA.
- wready SHALL be high in W_IDLE and W_HAVE_ADDR.
REQ-014 SHALL accept AW and W in either order or in the same cycle.
- On the completing handshake, the register SHALL update on the next edge and the FSM SHALL enter W_RESP.
- In W_RESP, bvalid SHALL be high and both readies SHALL be low.
REQ-015 SHALL hold bvalid and bresp stable until bready, then return to W_IDLE; back-to-back writes SHALL therefore take at least 2 cycles each.
REQ-016 SHALL run a read FSM with states R_IDLE (arready=1) and R_DATA (rvalid=1).
- rdata and rresp SHALL be registered on the AR handshake, giving 1-cycle latency.
- The read data SHALL be held stable until rready.
REQ-017 SHALL set resp=OKAY (2'b00) for mapped addresses.
- Unmapped addresses and writes to RO registers SHALL return SLVERR (2'b10).
- Such writes SHALL change no state; such reads SHALL return 0.
REQ-018 SHALL let a read and a write to the same register in the same cycle return the pre-write value.
REQ-019 SHALL drive ctrl_enable, ctrl_force_sub and operand directly from flops, updating 1 cycle after the completing write handshake.

Reset
REQ-020 SHALL, on axil_arst, synchronously force both FSMs to idle with all readies and valids low for that cycle.
- CTRL SHALL reset to CTRL_RST; OPERAND, SCRATCH, rdata and resps SHALL reset to 0.
REQ-021 SHALL abandon any in-flight transaction when reset asserts mid-operation, including a pending bvalid or rvalid, with no response issued.

Configuration
REQ-022 SHALL, with ADDSUB_STATS_EN defined, add RO registers 0x1010 ADD_CNT and 0x1014 SUB_CNT.
- Each SHALL count its evt pulses and saturate at 32'hFFFFFFFF.
- Any write to either register SHALL clear that counter and return OKAY.
- A clear SHALL win over a same-cycle event.
- Both counters SHALL reset to 0.
REQ-023 SHALL, without ADDSUB_STATS_EN, treat 0x1010 and 0x1014 as unmapped (SLVERR), with add_evt and sub_evt ignored.

Structure
REQ-024 SHALL place register offsets, the ID constant, resp encodings and the FSM state enums in package addsub_regs_pkg.
REQ-025 SHALL be a single module with no sub-modules; the counter logic is inline under the macro.

Verification
REQ-026 SHALL cover: write 0x1000=0x1 with AW and W in the same cycle -> bresp=OKAY, ctrl_enable=1 one cycle after the handshake.
REQ-027 SHALL cover: AW to 0x1004 with W 3 cycles later (value 0x5), then the reverse order -> both OKAY, operand=0x5, bvalid held across 4 cycles of bready=0.
REQ-028 SHALL cover: read 0x0000 -> rdata=0x41445342 with OKAY; read 0x2000 -> rdata=0 with SLVERR; write 0x1008 -> SLVERR and STATUS unchanged.
REQ-029 SHALL cover: axil_arst asserted while bvalid is pending -> bvalid=0 and CTRL=CTRL_RST next cycle, with no response after release.
REQ-030 SHALL cover, with ADDSUB_STATS_EN: 3 add_evt pulses -> ADD_CNT=3; write 0x1010 in the same cycle as an add_evt -> ADD_CNT=0.
REQ-031 SHALL cover, without ADDSUB_STATS_EN: read 0x1010 -> SLVERR.

Source files
------------

// File: rtl/addsub_regs_pkg.sv
// rtl/addsub_regs_pkg.sv - register map, response codes and FSM states for addsub_axil_regs
package addsub_regs_pkg;

    // Byte offsets of the register map (only bits [15:2] are decoded)
    localparam logic [15:0] ADDR_ID      = 16'h0000;
    localparam logic [15:0] ADDR_CTRL    = 16'h1000;
    localparam logic [15:0] ADDR_OPERAND = 16'h1004;
    localparam logic [15:0] ADDR_STATUS  = 16'h1008;
    localparam logic [15:0] ADDR_SCRATCH = 16'h100C;
    localparam logic [15:0] ADDR_ADD_CNT = 16'h1010;
    localparam logic [15:0] ADDR_SUB_CNT = 16'h1014;

    // Word indices as seen by the decoder
    localparam logic [13:0] IDX_ID      = ADDR_ID[15:2];
    localparam logic [13:0] IDX_CTRL    = ADDR_CTRL[15:2];
    localparam logic [13:0] IDX_OPERAND = ADDR_OPERAND[15:2];
    localparam logic [13:0] IDX_STATUS  = ADDR_STATUS[15:2];
    localparam logic [13:0] IDX_SCRATCH = ADDR_SCRATCH[15:2];
    localparam logic [13:0] IDX_ADD_CNT = ADDR_ADD_CNT[15:2];
    localparam logic [13:0] IDX_SUB_CNT = ADDR_SUB_CNT[15:2];

    localparam logic [31:0] ID_VALUE = 32'h41445342;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/addsub_axil_regs.sv
// rtl/addsub_axil_regs.sv - AXI4-Lite register block for the add/sub calculator
//
// Optional feature macro: ADDSUB_STATS_EN (adds ADD_CNT / SUB_CNT event counters).
//
// Ports:
//   axil_aclk, axil_arst        clock, synchronous active-high reset
//   s_axil_aw* / s_axil_w*      write address / write data channels (full-word writes)
//   s_axil_b*                   write response channel
//   s_axil_ar* / s_axil_r*      read address / read data channels
//   ctrl_enable, ctrl_force_sub CTRL[0], CTRL[1]
//   operand                     OPERAND register
//   status                      datapath status word, sampled every cycle
//   add_evt, sub_evt            one-cycle operation pulses (counted with ADDSUB_STATS_EN)
module addsub_axil_regs
    import addsub_regs_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic              axil_aclk,
    input  logic              axil_arst,

    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [ADDR_W-1:0] s_axil_awaddr,

    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    input  logic [31:0]       s_axil_wdata,

    output logic              s_axil_bvalid,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_bready,

    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    input  logic [ADDR_W-1:0] s_axil_araddr,

    output logic              s_axil_rvalid,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    input  logic              s_axil_rready,

    output logic              ctrl_enable,
    output logic              ctrl_force_sub,
    output logic [31:0]       operand,

    input  logic [31:0]       status,
    input  logic              add_evt,
    input  logic              sub_evt
);

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;

    logic [13:0] aw_idx_q;
    logic [31:0] wdata_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic [1:0]  ctrl_q;
    logic [31:0] operand_q;
    logic [31:0] status_q;
    logic [31:0] scratch_q;

    logic        wr_fire;
    logic [13:0] wr_idx;
    logic [31:0] wr_data;
    logic [1:0]  wr_resp;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

`ifdef ADDSUB_STATS_EN
    logic [31:0] add_cnt_q;
    logic [31:0] sub_cnt_q;
`endif

    // Channel handshakes are masked during reset so nothing is accepted or
    // presented in the reset cycle, whatever state the FSMs were in.
    assign s_axil_awready = !axil_arst && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
    assign s_axil_wready  = !axil_arst && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
    assign s_axil_bvalid  = !axil_arst && (w_state_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = !axil_arst && (r_state_q == R_IDLE);
    assign s_axil_rvalid  = !axil_arst && (r_state_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign ctrl_enable    = ctrl_q[0];
    assign ctrl_force_sub = ctrl_q[1];
    assign operand        = operand_q;

    // Write FSM: the completing handshake selects address/data from either the
    // live bus or the half captured earlier.
    always_comb begin
        w_state_d = w_state_q;
        wr_fire   = 1'b0;
        wr_idx    = aw_idx_q;
        wr_data   = wdata_q;
        case (w_state_q)
            W_IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid) begin
                    wr_fire = 1'b1;
                    wr_idx  = s_axil_awaddr[15:2];
                    wr_data = s_axil_wdata;
                end else if (s_axil_awvalid) begin
                    w_state_d = W_HAVE_ADDR;
                end else if (s_axil_wvalid) begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (s_axil_wvalid) begin
                    wr_fire = 1'b1;
                    wr_data = s_axil_wdata;
                end
            end
            W_HAVE_DATA: begin
                if (s_axil_awvalid) begin
                    wr_fire = 1'b1;
                    wr_idx  = s_axil_awaddr[15:2];
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_fire) begin
            w_state_d = W_RESP;
        end
    end

    always_comb begin
        wr_resp = RESP_OKAY;
        case (wr_idx)
            IDX_CTRL, IDX_OPERAND, IDX_SCRATCH: wr_resp = RESP_OKAY;
`ifdef ADDSUB_STATS_EN
            IDX_ADD_CNT, IDX_SUB_CNT:           wr_resp = RESP_OKAY;
`endif
            default:                            wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (s_axil_arvalid) r_state_d = R_DATA;
            R_DATA:  if (s_axil_rready)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read mux sees register values before any same-edge write lands.
    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (s_axil_araddr[15:2])
            IDX_ID:      rd_data = ID_VALUE;
            IDX_CTRL:    rd_data = {30'h0, ctrl_q};
            IDX_OPERAND: rd_data = operand_q;
            IDX_STATUS:  rd_data = status_q;
            IDX_SCRATCH: rd_data = scratch_q;
`ifdef ADDSUB_STATS_EN
            IDX_ADD_CNT: rd_data = add_cnt_q;
            IDX_SUB_CNT: rd_data = sub_cnt_q;
`endif
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_arst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_idx_q  <= 14'h0;
            wdata_q   <= 32'h0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            ctrl_q    <= CTRL_RST[1:0];
            operand_q <= 32'h0;
            status_q  <= 32'h0;
            scratch_q <= 32'h0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            status_q  <= status;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_idx_q <= s_axil_awaddr[15:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                wdata_q <= s_axil_wdata;
            end
            if (wr_fire) begin
                bresp_q <= wr_resp;
                case (wr_idx)
                    IDX_CTRL:    ctrl_q    <= wr_data[1:0];
                    IDX_OPERAND: operand_q <= wr_data;
                    IDX_SCRATCH: scratch_q <= wr_data;
                    default:     ;
                endcase
            end
            if (s_axil_arvalid && s_axil_arready) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

`ifdef ADDSUB_STATS_EN
    // Saturating event counters; a write clear beats a same-cycle event.
    always_ff @(posedge axil_aclk) begin
        if (axil_arst) begin
            add_cnt_q <= 32'h0;
            sub_cnt_q <= 32'h0;
        end else begin
            if (wr_fire && wr_idx == IDX_ADD_CNT) begin
                add_cnt_q <= 32'h0;
            end else if (add_evt && add_cnt_q != 32'hFFFF_FFFF) begin
                add_cnt_q <= add_cnt_q + 32'd1;
            end
            if (wr_fire && wr_idx == IDX_SUB_CNT) begin
                sub_cnt_q <= 32'h0;
            end else if (sub_evt && sub_cnt_q != 32'hFFFF_FFFF) begin
                sub_cnt_q <= sub_cnt_q + 32'd1;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awaddr, s_axil_araddr, wr_data};
`else
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awaddr, s_axil_araddr, wr_data, add_evt, sub_evt};
`endif

endmodule

// File: tb/tb_addsub_axil_regs.sv
// tb/tb_addsub_axil_regs.sv - scoreboard-driven directed bench for addsub_axil_regs
module tb_addsub_axil_regs;

    localparam logic [31:0] TB_CTRL_RST = 32'h0000_0002;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        axil_arst;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_wvalid, s_axil_wready;
    logic [31:0] s_axil_wdata;
    logic        s_axil_bvalid;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bready;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_rvalid;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rready;
    logic        ctrl_enable, ctrl_force_sub;
    logic [31:0] operand;
    logic [31:0] status;
    logic        add_evt, sub_evt;

    int total = 0;
    int bad   = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    logic        snap_en, snap_fs;
    logic [31:0] snap_op;

    always #5 clk = ~clk;

    addsub_axil_regs #(
        .ADDR_W   (32),
        .CTRL_RST (TB_CTRL_RST)
    ) dut (
        .axil_aclk      (clk),
        .axil_arst      (axil_arst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bready  (s_axil_bready),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rready  (s_axil_rready),
        .ctrl_enable    (ctrl_enable),
        .ctrl_force_sub (ctrl_force_sub),
        .operand        (operand),
        .status         (status),
        .add_evt        (add_evt),
        .sub_evt        (sub_evt)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp, input logic evt_at_hs);
        int cyc;
        bit aw_done, w_done;
        logic [1:0] exp_b;
        cyc = 0;
        aw_done = 0;
        w_done = 0;
        bq.push_back(exp_resp);
        s_axil_awaddr = addr;
        s_axil_wdata  = data;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            s_axil_wvalid  = !w_done && (cyc >= w_dly);
            add_evt = evt_at_hs && s_axil_awvalid && s_axil_wvalid;
            if (s_axil_awvalid && s_axil_awready) aw_done = 1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1;
            @(negedge clk);
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        add_evt        = 1'b0;
        chk("aw_w_accepted", 64'({aw_done, w_done}), 64'(2'b11));
        snap_en = ctrl_enable;
        snap_fs = ctrl_force_sub;
        snap_op = operand;
        chk("bvalid_after_hs", 64'(s_axil_bvalid), 64'(1'b1));
        chk("readies_low_in_resp", 64'({s_axil_awready, s_axil_wready}), 64'(2'b00));
        if (b_dly < 0) return;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 64'({s_axil_bvalid, s_axil_bresp}), 64'({1'b1, bq[0]}));
        end
        exp_b = bq.pop_front();
        chk($sformatf("bresp_%h", addr), 64'(s_axil_bresp), 64'(exp_b));
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
        chk("bvalid_clear", 64'(s_axil_bvalid), 64'(1'b0));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int r_dly);
        int cyc;
        logic [33:0] exp_r;
        rq.push_back({exp_resp, exp_data});
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        cyc = 0;
        while (!s_axil_arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        chk("rvalid_after_ar", 64'(s_axil_rvalid), 64'(1'b1));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("rdata_hold", 64'({s_axil_rvalid, s_axil_rresp, s_axil_rdata}), 64'({1'b1, rq[0]}));
        end
        exp_r = rq.pop_front();
        chk($sformatf("rd_%h", addr), 64'({s_axil_rresp, s_axil_rdata}), 64'(exp_r));
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
        chk("rvalid_clear", 64'(s_axil_rvalid), 64'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_b;
        logic [33:0] exp_r;

        axil_arst = 1'b1;
        s_axil_awvalid = 1'b0; s_axil_awaddr = 32'h0;
        s_axil_wvalid  = 1'b0; s_axil_wdata  = 32'h0;
        s_axil_bready  = 1'b0;
        s_axil_arvalid = 1'b0; s_axil_araddr = 32'h0;
        s_axil_rready  = 1'b0;
        status  = 32'hCAFE_0001;
        add_evt = 1'b0;
        sub_evt = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_handshakes_low", 64'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}), 64'(5'b0));
        axil_arst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", 64'({ctrl_force_sub, ctrl_enable}), 64'(TB_CTRL_RST[1:0]));
        chk("rst_operand", 64'(operand), 64'(32'h0));
        chk("idle_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));

        axi_read(32'h0000_0000, 32'h4144_5342, OKAY, 0);
        axi_read(32'h0000_1000, TB_CTRL_RST, OKAY, 0);

        // AW and W together
        axi_write(32'h0000_1000, 32'h0000_0001, 0, 0, 0, OKAY, 1'b0);
        chk("ctrl_en_next_cycle", 64'({snap_fs, snap_en}), 64'(2'b01));

        // AW leads W by 3 cycles, then W leads AW with a stalled response
        axi_write(32'h0000_1004, 32'h0000_0005, 0, 3, 0, OKAY, 1'b0);
        chk("operand_aw_first", 64'(snap_op), 64'(32'h5));
        axi_write(32'h0000_1004, 32'h0000_0005, 3, 0, 4, OKAY, 1'b0);
        chk("operand_w_first", 64'(operand), 64'(32'h5));
        axi_write(32'h0000_100C, 32'hA5A5_0001, 2, 0, 2, OKAY, 1'b0);

        // Error paths
        axi_read(32'h0000_2000, 32'h0, SLVERR, 0);
        axi_read(32'h0000_1008, 32'hCAFE_0001, OKAY, 0);
        axi_write(32'h0000_1008, 32'h1234_5678, 0, 0, 0, SLVERR, 1'b0);
        axi_read(32'h0000_1008, 32'hCAFE_0001, OKAY, 0);
        axi_write(32'h0000_0000, 32'h0, 0, 0, 1, SLVERR, 1'b0);
        axi_read(32'h0000_0000, 32'h4144_5342, OKAY, 0);

        // CTRL keeps only two bits; upper address bits ignored
        axi_write(32'h0000_1000, 32'hFFFF_FFFF, 0, 0, 0, OKAY, 1'b0);
        chk("ctrl_both_bits", 64'({ctrl_force_sub, ctrl_enable}), 64'(2'b11));
        axi_read(32'h0000_1000, 32'h0000_0003, OKAY, 0);
        axi_read(32'h0001_100C, 32'hA5A5_0001, OKAY, 0);
        axi_read(32'h0000_1004, 32'h0000_0005, OKAY, 3);

        // Same-cycle read and write of SCRATCH returns the old value
        bq.push_back(OKAY);
        rq.push_back({OKAY, 32'hA5A5_0001});
        s_axil_awaddr = 32'h0000_100C; s_axil_awvalid = 1'b1;
        s_axil_wdata  = 32'h1234_5678; s_axil_wvalid  = 1'b1;
        s_axil_araddr = 32'h0000_100C; s_axil_arvalid = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        chk("rw_same_valids", 64'({s_axil_bvalid, s_axil_rvalid}), 64'(2'b11));
        exp_b = bq.pop_front();
        exp_r = rq.pop_front();
        chk("rw_same_bresp", 64'(s_axil_bresp), 64'(exp_b));
        chk("rw_same_rdata", 64'({s_axil_rresp, s_axil_rdata}), 64'(exp_r));
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        axi_read(32'h0000_100C, 32'h1234_5678, OKAY, 0);

`ifdef ADDSUB_STATS_EN
        for (int i = 0; i < 3; i++) begin
            add_evt = 1'b1;
            @(negedge clk);
            add_evt = 1'b0;
            @(negedge clk);
        end
        sub_evt = 1'b1;
        repeat (2) @(negedge clk);
        sub_evt = 1'b0;
        axi_read(32'h0000_1010, 32'd3, OKAY, 0);
        axi_read(32'h0000_1014, 32'd2, OKAY, 0);
        axi_write(32'h0000_1010, 32'h0, 0, 0, 0, OKAY, 1'b1);
        axi_read(32'h0000_1010, 32'd0, OKAY, 0);
        axi_write(32'h0000_1014, 32'hFFFF_FFFF, 0, 0, 0, OKAY, 1'b0);
        axi_read(32'h0000_1014, 32'd0, OKAY, 0);
`else
        add_evt = 1'b1;
        @(negedge clk);
        add_evt = 1'b0;
        axi_read(32'h0000_1010, 32'h0, SLVERR, 0);
        axi_read(32'h0000_1014, 32'h0, SLVERR, 0);
        axi_write(32'h0000_1010, 32'h0, 0, 0, 0, SLVERR, 1'b0);
`endif

        // Reset while a write response is pending
        axi_write(32'h0000_1000, 32'h0000_0001, 0, 0, -1, OKAY, 1'b0);
        chk("pre_rst_ctrl", 64'({snap_fs, snap_en}), 64'(2'b01));
        void'(bq.pop_front());
        axil_arst = 1'b1;
        @(negedge clk);
        chk("rst_mid_bvalid", 64'(s_axil_bvalid), 64'(1'b0));
        chk("rst_mid_ctrl", 64'({ctrl_force_sub, ctrl_enable}), 64'(TB_CTRL_RST[1:0]));
        axil_arst = 1'b0;
        s_axil_bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 64'({s_axil_bvalid, s_axil_rvalid}), 64'(2'b00));
        end
        s_axil_bready = 1'b0;
        axi_read(32'h0000_1000, TB_CTRL_RST, OKAY, 0);
        axi_read(32'h0000_100C, 32'h0, OKAY, 0);

        chk("scoreboard_empty", 64'(bq.size() + rq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
